// File: rtl/spi_cfg_pkg.sv
// Shared constants and FSM state type for the SPI configuration register file.
package spi_cfg_pkg;

    localparam int CMD_W  = 8;
    localparam int ADDR_W = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CMD    = 2'd1,
        DATA   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    // Register map of the SDR config path
    localparam int PHASE_INC = 0;
    localparam int GAIN      = 1;
    localparam int MODE      = 2;
    localparam int SPARE     = 3;

endpackage

// File: rtl/spi_pin_sync.sv
// Three-flop synchroniser for one slow SPI pin; gives the synchronised level
// (after two flops) and single-cycle rise/fall pulses from the third flop.
module spi_pin_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic CLK,
    input  logic RSTb,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] sync_r;

    // Shift the raw pin through the synchroniser chain
    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            sync_r <= {3{RST_VAL}};
        end else begin
            sync_r <= {sync_r[1:0], pin};
        end
    end

    assign level = sync_r[1];
    assign rise  = sync_r[1] & ~sync_r[2];
    assign fall  = ~sync_r[1] & sync_r[2];

endmodule

// File: rtl/spi_cfg_regfile.sv
// SPI slave register file: 8-bit {rw, addr} command then DATA_W data bits.
// Optional MISO readback is enabled by defining SPI_CFG_READBACK_EN.
module spi_cfg_regfile
    import spi_cfg_pkg::*;
#(
    parameter int                           DATA_W    = 24,
    parameter int                           NUM_REGS  = 4,
    parameter logic [NUM_REGS*DATA_W-1:0]   RESET_VAL = {(NUM_REGS*DATA_W){1'b0}}
) (
    input  logic                         CLK,
    input  logic                         RSTb,
    input  logic                         SCK,
    input  logic                         CS,
    input  logic                         MOSI,
    output logic                         MISO,
    output logic [NUM_REGS*DATA_W-1:0]   regs,
    output logic [NUM_REGS-1:0]          wr_stb,
    output logic                         frame_err
);

    localparam int CNT_W = $clog2(DATA_W + 2);

    logic              cs_lvl_s, cs_rise_s, cs_fall_s;
    logic              sck_lvl_s, sck_rise_s, sck_fall_s;
    logic              mosi_lvl_s, mosi_rise_s, mosi_fall_s;

    state_t            state_r;
    logic [DATA_W-1:0] shift_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              rw_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] regs_r [NUM_REGS];
    logic [NUM_REGS-1:0] wr_stb_r;
    logic              frame_err_r;

    logic              cmd_done_s;
    logic              cmd_rw_s;
    logic [ADDR_W-1:0] cmd_addr_s;
    logic              in_range_s;

    spi_pin_sync #(.RST_VAL(1'b1)) u_sync_cs (
        .CLK(CLK), .RSTb(RSTb), .pin(CS),
        .level(cs_lvl_s), .rise(cs_rise_s), .fall(cs_fall_s)
    );

    spi_pin_sync #(.RST_VAL(1'b0)) u_sync_sck (
        .CLK(CLK), .RSTb(RSTb), .pin(SCK),
        .level(sck_lvl_s), .rise(sck_rise_s), .fall(sck_fall_s)
    );

    spi_pin_sync #(.RST_VAL(1'b0)) u_sync_mosi (
        .CLK(CLK), .RSTb(RSTb), .pin(MOSI),
        .level(mosi_lvl_s), .rise(mosi_rise_s), .fall(mosi_fall_s)
    );

    // The eighth command bit is still on the MOSI sync output when the command completes
    assign cmd_rw_s   = shift_r[CMD_W-2];
    assign cmd_addr_s = {shift_r[ADDR_W-2:0], mosi_lvl_s};
    assign cmd_done_s = (state_r == CMD) && !cs_rise_s && sck_rise_s
                        && (cnt_r == CNT_W'(CMD_W - 1));
    assign in_range_s = ({1'b0, addr_r} < 8'(NUM_REGS));

    // Frame FSM, shift register and register storage
    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            state_r     <= IDLE;
            shift_r     <= {DATA_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            rw_r        <= 1'b0;
            addr_r      <= {ADDR_W{1'b0}};
            wr_stb_r    <= {NUM_REGS{1'b0}};
            frame_err_r <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= RESET_VAL[i*DATA_W +: DATA_W];
            end
        end else begin
            wr_stb_r    <= {NUM_REGS{1'b0}};
            frame_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (cs_fall_s) begin
                        state_r <= CMD;
                        shift_r <= {DATA_W{1'b0}};
                        cnt_r   <= {CNT_W{1'b0}};
                    end
                end
                CMD: begin
                    if (cs_rise_s) begin
                        state_r     <= IDLE;
                        frame_err_r <= 1'b1;
                    end else if (cmd_done_s) begin
                        rw_r    <= cmd_rw_s;
                        addr_r  <= cmd_addr_s;
                        shift_r <= {DATA_W{1'b0}};
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= DATA;
                    end else if (sck_rise_s) begin
                        shift_r <= {shift_r[DATA_W-2:0], mosi_lvl_s};
                        cnt_r   <= cnt_r + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cs_rise_s) begin
                        if (cnt_r == CNT_W'(DATA_W)) begin
                            state_r <= COMMIT;
                        end else begin
                            state_r     <= IDLE;
                            frame_err_r <= 1'b1;
                        end
                    end else if (sck_rise_s) begin
                        shift_r <= {shift_r[DATA_W-2:0], mosi_lvl_s};
                        if (cnt_r != CNT_W'(DATA_W + 1)) begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                end
                COMMIT: begin
                    state_r <= IDLE;
                    if (!in_range_s) begin
                        frame_err_r <= 1'b1;
                    end else if (!rw_r) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (addr_r == ADDR_W'(i)) begin
                                regs_r[i]   <= shift_r;
                                wr_stb_r[i] <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs[g*DATA_W +: DATA_W] = regs_r[g];
    end

    assign wr_stb    = wr_stb_r;
    assign frame_err = frame_err_r;

`ifdef SPI_CFG_READBACK_EN
    logic [DATA_W-1:0] rd_word_s;
    logic [DATA_W-1:0] miso_sh_r;
    logic              miso_r;

    // Select the addressed register for readback; out-of-range reads as zero
    always_comb begin
        rd_word_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            if (cmd_addr_s == ADDR_W'(i)) begin
                rd_word_s = regs_r[i];
            end else begin
                rd_word_s = rd_word_s;
            end
        end
    end

    // MISO shifter; the first SCK fall after the command keeps the preloaded MSB
    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            miso_r    <= 1'b0;
            miso_sh_r <= {DATA_W{1'b0}};
        end else if (cmd_done_s && cmd_rw_s) begin
            miso_r    <= rd_word_s[DATA_W-1];
            miso_sh_r <= {rd_word_s[DATA_W-2:0], 1'b0};
        end else if ((state_r == DATA) && rw_r && !cs_lvl_s && sck_fall_s
                     && (cnt_r != {CNT_W{1'b0}})) begin
            miso_r    <= miso_sh_r[DATA_W-1];
            miso_sh_r <= {miso_sh_r[DATA_W-2:0], 1'b0};
        end else if ((state_r != DATA) || cs_lvl_s) begin
            miso_r <= 1'b0;
        end
    end

    assign MISO = miso_r;
`else
    assign MISO = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cfg_regfile.sv
// Scoreboard bench for spi_cfg_regfile: randomized SPI frames, queue of expected events.
module tb_spi_cfg_regfile;

    localparam int DW = 24;
    localparam int NR = 4;
    localparam int H  = 6;
    localparam logic [NR*DW-1:0] RV = {24'h0F0F0F, 24'h00C0DE, 24'hA5A5A5, 24'h123456};

    logic CLK = 1'b0;
    logic RSTb, SCK, CS, MOSI, MISO, frame_err;
    logic [NR*DW-1:0] regs;
    logic [NR-1:0] wr_stb;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        bit              is_err;
        int              addr;
        int              cyc;
        logic [NR*DW-1:0] regs;
    } exp_t;

    exp_t q[$];
    logic [DW-1:0] mdl [NR];

    spi_cfg_regfile #(.DATA_W(DW), .NUM_REGS(NR), .RESET_VAL(RV)) dut (
        .CLK(CLK), .RSTb(RSTb), .SCK(SCK), .CS(CS), .MOSI(MOSI),
        .MISO(MISO), .regs(regs), .wr_stb(wr_stb), .frame_err(frame_err)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    function automatic logic [NR*DW-1:0] model_regs();
        logic [NR*DW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = mdl[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) mdl[i] = RV[i*DW +: DW];
    endtask

    task automatic push(input bit is_err, input int addr, input int lat);
        exp_t e;
        e.is_err = is_err;
        e.addr   = addr;
        e.cyc    = cyc + lat;
        e.regs   = model_regs();
        q.push_back(e);
    endtask

    // One SPI mode-0 frame of nbits; the model decides the expected outcome
    task automatic spi_frame(input bit rw, input bit [6:0] addr, input bit [DW-1:0] data,
                             input int nbits, input bit abort, output logic [DW-1:0] rd);
        bit [7:0] cmd;
        cmd = {rw, addr};
        rd = '0;
        CS = 1'b0;
        wait_clk(4);
        for (int i = 0; i < nbits; i++) begin
            if (i < 8) MOSI = cmd[7-i];
            else if (i < 8 + DW) MOSI = data[DW-1-(i-8)];
            else MOSI = 1'($urandom_range(0, 1));
            wait_clk(H);
            if (i >= 8 && i < 8 + DW) rd = {rd[DW-2:0], MISO};
            SCK = 1'b1;
            wait_clk(H);
            SCK = 1'b0;
        end
        wait_clk(H);
        if (abort) begin
            RSTb = 1'b0;
            wait_clk(3);
            CS = 1'b1;
            wait_clk(3);
            RSTb = 1'b1;
            model_reset();
            wait_clk(6);
            return;
        end
        if (nbits != 8 + DW) push(1'b1, int'(addr), 3);
        else if (int'(addr) >= NR) push(1'b1, int'(addr), 4);
        else if (!rw) begin
            mdl[int'(addr)] = data;
            push(1'b0, int'(addr), 4);
        end
        CS = 1'b1;
        wait_clk(12);
    endtask

    // Monitor: every strobe or error pulse is matched against the oldest expectation
    always @(negedge CLK) begin
        if (RSTb === 1'b1 && (wr_stb !== '0 || frame_err !== 1'b0)) begin
            exp_t e;
            chk("stb_err_exclusive", 128'(wr_stb != '0 && frame_err), 128'(0));
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event: wr_stb=%b frame_err=%b, nothing expected (cycle %0d)",
                         wr_stb, frame_err, cyc);
            end else begin
                e = q.pop_front();
                chk("event_cycle", 128'(cyc), 128'(e.cyc));
                if (e.is_err) begin
                    chk("frame_err", 128'(frame_err), 128'(1));
                    chk("wr_stb_on_err", 128'(wr_stb), 128'(0));
                end else begin
                    chk("wr_stb", 128'(wr_stb), 128'(NR'(1) << e.addr));
                end
                chk("regs_at_event", 128'(regs), 128'(e.regs));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] rd;
        logic [DW-1:0] exp_rd;
        int k, nb;
        bit [6:0] a;
        bit [DW-1:0] d;

        RSTb = 1'b0; CS = 1'b1; SCK = 1'b0; MOSI = 1'b0;
        model_reset();
        wait_clk(5);
        RSTb = 1'b1;
        wait_clk(2);
        chk("reset_regs", 128'(regs), 128'(RV));
        chk("reset_wr_stb", 128'(wr_stb), 128'(0));
        chk("reset_frame_err", 128'(frame_err), 128'(0));
        chk("reset_miso", 128'(MISO), 128'(0));

        spi_frame(1'b0, 7'd1, 24'h000005, 8 + DW, 1'b0, rd);
        chk("write_addr1", 128'(regs), 128'(model_regs()));

        spi_frame(1'b0, 7'd2, 24'h111111, 8 + DW - 1, 1'b0, rd);
        spi_frame(1'b0, 7'd2, 24'h222222, 8 + DW + 1, 1'b0, rd);
        chk("bad_len_no_write", 128'(regs), 128'(model_regs()));

        spi_frame(1'b0, 7'h7F, 24'h333333, 8 + DW, 1'b0, rd);
        chk("bad_addr_no_write", 128'(regs), 128'(model_regs()));

        spi_frame(1'b0, 7'd3, 24'h444444, 8 + 10, 1'b1, rd);
        chk("reset_mid_frame", 128'(regs), 128'(RV));
        spi_frame(1'b0, 7'd0, 24'h0071F3, 8 + DW, 1'b0, rd);
        chk("write_after_reset", 128'(regs), 128'(model_regs()));

        spi_frame(1'b0, 7'd2, 24'hABCDEF, 8 + DW, 1'b0, rd);
        spi_frame(1'b1, 7'd2, 24'h000000, 8 + DW, 1'b0, rd);
`ifdef SPI_CFG_READBACK_EN
        exp_rd = 24'hABCDEF;
`else
        exp_rd = 24'h000000;
`endif
        chk("readback_addr2", 128'(rd), 128'(exp_rd));
        chk("read_no_change", 128'(regs), 128'(model_regs()));

        for (int it = 0; it < 30; it++) begin
            k = $urandom_range(0, 9);
            d = DW'($urandom);
            a = 7'($urandom_range(0, NR - 1));
            if (k <= 4) begin
                spi_frame(1'b0, a, d, 8 + DW, 1'b0, rd);
            end else if (k <= 6) begin
`ifdef SPI_CFG_READBACK_EN
                exp_rd = mdl[int'(a)];
`else
                exp_rd = '0;
`endif
                spi_frame(1'b1, a, d, 8 + DW, 1'b0, rd);
                chk("random_read", 128'(rd), 128'(exp_rd));
            end else if (k == 7) begin
                a = 7'($urandom_range(NR, 127));
                spi_frame(1'b0, a, d, 8 + DW, 1'b0, rd);
            end else begin
                nb = $urandom_range(0, 8 + DW + 3);
                if (nb == 8 + DW) nb++;
                spi_frame(1'($urandom_range(0, 1)), a, d, nb, 1'b0, rd);
            end
        end

        wait_clk(20);
        chk("final_regs", 128'(regs), 128'(model_regs()));
        chk("queue_drained", 128'(q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
